// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES datapath definitions: GF(2^8) reduction constant, state /
// column / byte types, the MixColumns FSM encoding and the xtime helper
// (multiply by 2 in GF(2^8)), which the inverse MixColumns path also uses.
// ---------------------------------------------------------------------------
package aes_pkg;

   // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1 (0x11B).
   localparam logic [7:0] AES_POLY_LSB = 8'h1B;

   typedef logic [127:0] aes_state_t;
   typedef logic [31:0]  aes_col_t;
   typedef logic [7:0]   aes_byte_t;

   typedef enum logic [1:0] {
      MC_IDLE = 2'd0,
      MC_BUSY = 2'd1,
      MC_DONE = 2'd2
   } mc_state_e;

   // Multiply by 2 in GF(2^8); the shifted-out bit folds back in as 0x1B.
   function automatic aes_byte_t xtime(input aes_byte_t x);
      return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY_LSB : 8'h00);
   endfunction

endpackage

// File: rtl/mix_single_column.sv
// ---------------------------------------------------------------------------
// mix_single_column
// Combinational forward MixColumns on one 32-bit column.
// Ports:
//   col_in  [31:0]  input column, row 0 in the MSB byte
//   col_out [31:0]  transformed column, same byte order
// ---------------------------------------------------------------------------
module mix_single_column
   import aes_pkg::*;
(
   input  logic [31:0] col_in,
   output logic [31:0] col_out
);

   aes_byte_t a0, a1, a2, a3;
   aes_byte_t x0, x1, x2, x3;

   assign a0 = col_in[31:24];
   assign a1 = col_in[23:16];
   assign a2 = col_in[15:8];
   assign a3 = col_in[7:0];

   assign x0 = xtime(a0);
   assign x1 = xtime(a1);
   assign x2 = xtime(a2);
   assign x3 = xtime(a3);

   // 3*a is expanded as xtime(a) ^ a.
   assign col_out[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
   assign col_out[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
   assign col_out[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
   assign col_out[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;

endmodule

// File: rtl/mix_columns_seq.sv
// ---------------------------------------------------------------------------
// mix_columns_seq
// Iterative forward AES MixColumns engine. A 128-bit state is loaded over a
// valid/ready handshake, COLS_PER_CYCLE columns are rewritten in place per
// clock, and the result is held on out_data until accepted.
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   in_data valid
//   in_ready   engine can accept a state (IDLE only)
//   in_data    input state, column c at [127-32c -: 32]
//   out_valid  out_data valid (DONE only)
//   out_ready  downstream accepts out_data
//   out_data   transformed state
//   busy       high while not IDLE
// ---------------------------------------------------------------------------
module mix_columns_seq
   import aes_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);

   localparam int N_STEPS = 4 / COLS_PER_CYCLE;
   localparam int STEP_W  = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

   generate
      if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
         $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   mc_state_e        state_q;
   logic [STEP_W-1:0] step_q;
   aes_state_t       data_q;
   aes_state_t       data_next;
   logic             last_step;

   logic [1:0] col_idx [COLS_PER_CYCLE];
   logic [6:0] col_lsb [COLS_PER_CYCLE];
   aes_col_t   col_in  [COLS_PER_CYCLE];
   aes_col_t   col_out [COLS_PER_CYCLE];

   // Column c lives at bit offset 32*(3-c); for a 2-bit index that is {~c, 5'b0}.
   always_comb begin
      for (int k = 0; k < COLS_PER_CYCLE; k++) begin
         col_idx[k] = 2'((32'(step_q) * COLS_PER_CYCLE) + k);
         col_lsb[k] = {~col_idx[k], 5'b0};
         col_in[k]  = data_q[col_lsb[k] +: 32];
      end
   end

   generate
      for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
         mix_single_column u_mix (
            .col_in  (col_in[g]),
            .col_out (col_out[g])
         );
      end
   endgenerate

   always_comb begin
      data_next = data_q;
      for (int k = 0; k < COLS_PER_CYCLE; k++) begin
         data_next[col_lsb[k] +: 32] = col_out[k];
      end
   end

   assign last_step = (step_q == STEP_W'(N_STEPS - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= MC_IDLE;
         step_q  <= '0;
         data_q  <= '0;
      end else begin
         case (state_q)
            MC_IDLE: begin
               if (in_valid) begin
                  data_q  <= in_data;
                  step_q  <= '0;
                  state_q <= MC_BUSY;
               end
            end
            MC_BUSY: begin
               data_q <= data_next;
               step_q <= step_q + STEP_W'(1);
               if (last_step) begin
                  state_q <= MC_DONE;
               end
            end
            MC_DONE: begin
               if (out_ready) begin
                  state_q <= MC_IDLE;
               end
            end
            default: state_q <= MC_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == MC_IDLE);
   assign out_valid = (state_q == MC_DONE);
   assign busy      = (state_q != MC_IDLE);
   assign out_data  = data_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// ---------------------------------------------------------------------------
// tb_mix_columns_seq
// Directed bench for mix_columns_seq: a COLS_PER_CYCLE=1 instance carries
// most scenarios, a COLS_PER_CYCLE=4 instance checks the short latency.
// ---------------------------------------------------------------------------
module tb_mix_columns_seq;

   logic         clk;
   logic         rst_n;
   logic         in_valid, in_ready, out_valid, out_ready, busy;
   logic [127:0] in_data, out_data;
   logic         in_valid4, in_ready4, out_valid4, out_ready4, busy4;
   logic [127:0] in_data4, out_data4;

   int errors = 0;
   int checks = 0;

   localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;

   mix_columns_seq #(.COLS_PER_CYCLE(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
      .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
      .busy(busy4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model
   function automatic logic [7:0] gmul2(input logic [7:0] x);
      logic [7:0] s;
      s = x << 1;
      return x[7] ? (s ^ 8'h1b) : s;
   endfunction

   function automatic logic [31:0] ref_col(input logic [31:0] c);
      logic [7:0] a [4];
      logic [7:0] b [4];
      for (int r = 0; r < 4; r++) a[r] = c[31-8*r -: 8];
      for (int r = 0; r < 4; r++)
         b[r] = gmul2(a[r]) ^ gmul2(a[(r+1)%4]) ^ a[(r+1)%4] ^ a[(r+2)%4] ^ a[(r+3)%4];
      return {b[0], b[1], b[2], b[3]};
   endfunction

   function automatic logic [127:0] ref_state(input logic [127:0] s);
      logic [127:0] r;
      for (int c = 0; c < 4; c++) r[127-32*c -: 32] = ref_col(s[127-32*c -: 32]);
      return r;
   endfunction

   // Drive helpers (no comparisons besides bounded-wait timeouts)
   task automatic send(input logic [127:0] din);
      int g;
      in_data  = din;
      in_valid = 1'b1;
      g = 0;
      while (!in_ready && g < 50) begin
         @(posedge clk); #1; g++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic wait_out(output int cyc);
      cyc = 1;
      while (!out_valid && cyc < 50) begin
         @(posedge clk); #1; cyc++;
      end
      if (!out_valid) begin
         checks++; errors++;
         $display("FAIL wait_out_timeout: out_valid=%b required 1", out_valid);
      end
   endtask

   task automatic accept_out;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
      checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data: got %h required 0", out_data); end
   endtask

   task automatic test_fips;
      int cyc;
      send(FIPS_IN);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fips_busy: got %b required 1", busy); end
      wait_out(cyc);
      checks++; if (cyc != 5) begin errors++; $display("FAIL fips_latency: got cycle %0d required 5", cyc); end
      checks++; if (out_data !== FIPS_OUT) begin errors++; $display("FAIL fips_data: got %h required %h", out_data, FIPS_OUT); end
      accept_out;
   endtask

   task automatic test_fips_c4;
      int cyc, g;
      in_data4  = FIPS_IN;
      in_valid4 = 1'b1;
      g = 0;
      while (!in_ready4 && g < 50) begin @(posedge clk); #1; g++; end
      @(posedge clk); #1;
      in_valid4 = 1'b0;
      in_data4  = '0;
      cyc = 1;
      while (!out_valid4 && cyc < 50) begin @(posedge clk); #1; cyc++; end
      checks++; if (cyc != 2) begin errors++; $display("FAIL c4_latency: got cycle %0d required 2", cyc); end
      checks++; if (out_data4 !== FIPS_OUT) begin errors++; $display("FAIL c4_data: got %h required %h", out_data4, FIPS_OUT); end
      out_ready4 = 1'b1;
      @(posedge clk); #1;
      out_ready4 = 1'b0;
      checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL c4_return_idle: in_ready=%b required 1", in_ready4); end
   endtask

   task automatic test_columns;
      logic [31:0] kin  [6] = '{32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5, 32'h2d26314c};
      logic [31:0] kout [6] = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6, 32'h4d7ebdf8};
      logic [127:0] din, exp;
      int cyc;
      for (int i = 0; i < 6; i++) begin
         din = {kin[i],  kin[(i+1)%6],  kin[(i+2)%6],  kin[(i+3)%6]};
         exp = {kout[i], kout[(i+1)%6], kout[(i+2)%6], kout[(i+3)%6]};
         send(din);
         wait_out(cyc);
         checks++; if (out_data !== exp) begin errors++; $display("FAIL columns_%0d: got %h required %h", i, out_data, exp); end
         accept_out;
      end
   endtask

   task automatic test_backpressure;
      logic [127:0] hold;
      int cyc;
      send(FIPS_IN);
      wait_out(cyc);
      hold = out_data;
      checks++; if (hold !== FIPS_OUT) begin errors++; $display("FAIL bp_data: got %h required %h", hold, FIPS_OUT); end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checks++;
         if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, hold}) begin
            errors++;
            $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b data=%h required 1 0 %h", i, out_valid, in_ready, out_data, hold);
         end
      end
      accept_out;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_after: got %b required 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_out_valid_after: got %b required 0", out_valid); end
   endtask

   task automatic test_ignored_input;
      logic [127:0] a;
      int g;
      a = 128'h0123456789abcdeffedcba9876543210;
      send(a);
      g = 0;
      while (!out_valid && g < 50) begin
         in_valid = ~in_valid;
         in_data  = {$urandom, $urandom, $urandom, $urandom};
         @(posedge clk); #1; g++;
      end
      in_valid = 1'b0;
      checks++; if (out_data !== ref_state(a)) begin errors++; $display("FAIL ignored_data: got %h required %h", out_data, ref_state(a)); end
      accept_out;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ignored_no_second_%0d: busy=%b out_valid=%b required 0 0", i, busy, out_valid);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_mid;
      int cyc;
      send(FIPS_IN);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b required 0", out_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b required 0", busy); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b required 1", in_ready); end
      checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL midrst_out_data: got %h required 0", out_data); end
      send(FIPS_IN);
      wait_out(cyc);
      checks++; if (out_data !== FIPS_OUT) begin errors++; $display("FAIL midrst_fresh: got %h required %h", out_data, FIPS_OUT); end
      accept_out;
   endtask

   task automatic test_back_to_back;
      logic [127:0] expq[$];
      logic [127:0] exp;
      int received;
      bit prod_done;
      received  = 0;
      prod_done = 0;
      fork
         begin : producer
            int g;
            for (int i = 0; i < 100; i++) begin
               in_data  = {$urandom, $urandom, $urandom, $urandom};
               in_valid = 1'b1;
               g = 0;
               forever begin
                  @(negedge clk);
                  if (in_ready || g > 200) break;
                  @(posedge clk); #1; g++;
               end
               if (in_ready) expq.push_back(ref_state(in_data));
               @(posedge clk); #1;
               in_valid = 1'b0;
               repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            prod_done = 1;
         end
         begin : consumer
            int cyc;
            cyc = 0;
            while (received < 100 && cyc < 20000) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 2) != 0);
               @(negedge clk);
               if (out_valid && out_ready) begin
                  checks++;
                  if (expq.size() == 0) begin
                     errors++;
                     $display("FAIL b2b_unexpected_%0d: got %h with nothing pending", received, out_data);
                  end else begin
                     exp = expq.pop_front();
                     if (out_data !== exp) begin
                        errors++;
                        $display("FAIL b2b_data_%0d: got %h required %h", received, out_data, exp);
                     end
                  end
                  received++;
               end
               cyc++;
            end
         end
      join
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++; if (received != 100) begin errors++; $display("FAIL b2b_count: got %0d required 100", received); end
      checks++; if (expq.size() != 0) begin errors++; $display("FAIL b2b_leftover: got %0d required 0", expq.size()); end
      checks++; if (prod_done != 1'b1) begin errors++; $display("FAIL b2b_producer: got %b required 1", prod_done); end
   endtask

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      out_ready  = 1'b0;
      in_valid4  = 1'b0;
      in_data4   = '0;
      out_ready4 = 1'b0;
      test_reset;
      test_fips;
      test_fips_c4;
      test_columns;
      test_backpressure;
      test_ignored_input;
      test_reset_mid;
      test_back_to_back;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mix_columns_seq.md
Name: mix_columns_seq

Overview:
- Forward AES MixColumns engine for the encrypt datapath; the counterpart of the decrypt-side inverse MixColumns.
- Accepts a 128-bit state over a valid/ready handshake and transforms COLS_PER_CYCLE columns per clock.
- Returns the result over a valid/ready handshake.
- Sits between ShiftRows and AddRoundKey in an iterative round datapath; it is not used in the final round.

Parameters:
- COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4. N_STEPS = 4/COLS_PER_CYCLE.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  in_data valid
- in_ready  output  1  engine can accept a state
- in_data  input  128  input state
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts out_data
- out_data  output  128  transformed state
- busy  output  1  high while not IDLE

Behaviour:
- Byte layout: column c occupies [127-32c -: 32]. Within a column, row 0 is the MSB byte and row 3 the LSB byte.
- Per column (a0..a3 → b0..b3), GF(2^8) with poly 0x11B:
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
- Arithmetic: xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00); 3x = xtime(x)^x. All intermediate values are 8 bits; there is no carry out.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready, load in_data into the state register, clear step counter, go to BUSY.
  - BUSY: each clock replace columns [step*COLS_PER_CYCLE .. +COLS_PER_CYCLE-1] in place and increment step. When the last step is written, go to DONE.
  - DONE: out_valid=1 and out_data = state register. On out_ready go to IDLE. Otherwise hold, with out_data stable and unchanged.
- Latency: handshake in cycle 0, BUSY during cycles 1..N_STEPS, out_valid first high in cycle N_STEPS+1. Default is cycle 5; COLS_PER_CYCLE=4 gives cycle 2.
- Throughput: one state per N_STEPS+2 cycles minimum. in_ready is low in BUSY and DONE; no overlap and no input skid.
- in_valid while not IDLE is ignored and in_data is not sampled. in_data may change freely after the accepting edge.
- out_ready while not DONE has no effect.
- Step counter: log2(N_STEPS)-bit counter (1 bit minimum), wraps to 0 at load. For COLS_PER_CYCLE=4 BUSY lasts exactly one cycle.
- Reset (rst_n=0 at a rising edge, in any state including mid-BUSY and DONE):
  - Next state IDLE; the in-flight state is discarded.
  - Step counter and state register go to 0.
  - Outputs: out_valid=0, out_data=128'h0, busy=0, in_ready=1 (first cycle after reset release).
- out_data reads 0 in IDLE after reset. In DONE it holds the result until accepted. After acceptance it keeps the last result; this is don't-care but is not X.
- Illegal COLS_PER_CYCLE values are rejected by an elaboration-time check.

Decomposition:
- Shared package aes_pkg holds:
  - AES_POLY_LSB = 8'h1B
  - state/column/byte typedefs (128/32/8 bits)
  - FSM state enum for this block
  - function xtime, reused by the inverse path
- One combinational sub-module, mix_single_column (32-bit in, 32-bit out), instantiated COLS_PER_CYCLE times. Each instance sits behind a column-select mux driven by the step counter.

Test Plan:
- FIPS-197 App. B round 1: in_data = d4bf5d30e0b452aeb84111f11e2798e5 → out_data = 046681e5e0cb199a48f8d37a2806264c. out_valid must rise in cycle 5 for COLS_PER_CYCLE=1 and cycle 2 for COLS_PER_CYCLE=4.
- Known columns across all four positions: db135345→8e4da1bc, f20a225c→9fdc589d, 01010101→01010101, c6c6c6c6→c6c6c6c6, d4d4d4d5→d5d5d7d6, 2d26314c→4d7ebdf8.
- Backpressure: hold out_ready=0 for 10 cycles in DONE; out_data stable and in_ready=0 throughout. Pulse out_ready for one cycle; the next cycle is IDLE with in_ready=1.
- Ignored input: toggle in_valid with garbage in_data during BUSY. The result equals that of the originally accepted state, and no second transaction occurs.
- Reset mid-operation: assert rst_n=0 for one cycle at step 2. Next cycle: out_valid=0, busy=0, in_ready=1, out_data=0. A fresh App. B vector then completes correctly.
- Back-to-back: 100 random states with random out_ready gaps, checked against a reference model. Each result appears exactly once, in order.
